// File: rtl/mine_layout_ctrl_if.sv
// Bus bundle between the game FSM / random generator and the layout builder.
// Latency: none, wires only.
// Backpressure: none; board writes are strobed and must be taken every cycle.
//
// Signals:
//   start, total_mines, safe_row, safe_col   layout request from the game FSM
//   rand_row, rand_col                       free-running random cell source
//   busy, done, placed, mine_map             layout progress and result
//   wr_en, wr_addr, wr_mine, wr_count        per-cell write stream to the board
interface mine_layout_ctrl_if;
   logic        start;
   logic [3:0]  total_mines;
   logic [2:0]  safe_row;
   logic [2:0]  safe_col;
   logic [2:0]  rand_row;
   logic [2:0]  rand_col;
   logic        busy;
   logic        done;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic        wr_mine;
   logic [3:0]  wr_count;
   logic [3:0]  placed;
   logic [63:0] mine_map;

   // Requester side: game FSM, random generator and board storage.
   modport master (
      output start, total_mines, safe_row, safe_col, rand_row, rand_col,
      input  busy, done, wr_en, wr_addr, wr_mine, wr_count, placed, mine_map
   );

   // Layout builder side.
   modport slave (
      input  start, total_mines, safe_row, safe_col, rand_row, rand_col,
      output busy, done, wr_en, wr_addr, wr_mine, wr_count, placed, mine_map
   );
endinterface

// File: rtl/mine_layout_ctrl.sv
// Builds a random 8x8 minesweeper layout and streams one write per cell to the board.
// Latency: start to done is N + R + 64 cycles (N mines, R rejected candidates).
// Backpressure: none; the board must capture a write on every COUNT cycle.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    mine_layout_ctrl_if.slave (request, random source, write stream, status)
module mine_layout_ctrl (
   input  logic               clk,
   input  logic               reset,
   mine_layout_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLACE = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic [3:0]  total_q;
   logic [5:0]  safe_q;
   logic [63:0] mine_map_q;
   logic [3:0]  placed_q;
   logic [5:0]  scan_q;

   logic [5:0]  cand;
   logic        start_ok;
   logic        accept;
   logic        last_mine;

   logic        busy;
   logic        done;
   logic        wr_en;

   logic [2:0]  scan_row;
   logic [2:0]  scan_col;
   logic [7:0]  nb_ok;
   logic [5:0]  nb_idx [8];
   logic [7:0]  nb_hit;
   logic [3:0]  nb_cnt;

   // ------------------------------------------------------------------
   // Placement decision
   // ------------------------------------------------------------------
   assign cand      = {bus.rand_row, bus.rand_col};
   assign start_ok  = bus.start && ((state_q == IDLE) || (state_q == DONE));
   // A candidate is taken only if the cell is empty and not the first-click cell.
   assign accept    = (state_q == PLACE) && !mine_map_q[cand] && (cand != safe_q);
   assign last_mine = accept && ((placed_q + 4'd1) == total_q);

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and status decode
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d = (bus.total_mines == 4'd0) ? COUNT : PLACE;
            end
         end
         PLACE: begin
            busy = 1'b1;
            if (last_mine) begin
               state_d = COUNT;
            end
         end
         COUNT: begin
            busy  = 1'b1;
            wr_en = 1'b1;
            if (scan_q == 6'd63) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start_ok) begin
               state_d = (bus.total_mines == 4'd0) ? COUNT : PLACE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: request latch, mine bitmap, placed count, scan counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         total_q    <= 4'd0;
         safe_q     <= 6'd0;
         mine_map_q <= 64'd0;
         placed_q   <= 4'd0;
         scan_q     <= 6'd0;
      end else if (start_ok) begin
         total_q    <= bus.total_mines;
         safe_q     <= {bus.safe_row, bus.safe_col};
         mine_map_q <= 64'd0;
         placed_q   <= 4'd0;
         scan_q     <= 6'd0;
      end else begin
         if (accept) begin
            mine_map_q[cand] <= 1'b1;
            placed_q         <= placed_q + 4'd1;
         end
         // Wraps 63 -> 0 on the final write, so DONE/IDLE show address 0.
         if (state_q == COUNT) begin
            scan_q <= scan_q + 6'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Neighbour count for the cell under scan.
   // Index arithmetic wraps modulo 64, so each neighbour is qualified by
   // the row/column edge checks; this is what stops col 7 of one row being
   // counted as adjacent to col 0 of the next.
   // ------------------------------------------------------------------
   assign scan_row = scan_q[5:3];
   assign scan_col = scan_q[2:0];

   always_comb begin
      nb_ok[0]  = (scan_row != 3'd0) && (scan_col != 3'd0);   // up-left
      nb_ok[1]  = (scan_row != 3'd0);                         // up
      nb_ok[2]  = (scan_row != 3'd0) && (scan_col != 3'd7);   // up-right
      nb_ok[3]  = (scan_col != 3'd0);                         // left
      nb_ok[4]  = (scan_col != 3'd7);                         // right
      nb_ok[5]  = (scan_row != 3'd7) && (scan_col != 3'd0);   // down-left
      nb_ok[6]  = (scan_row != 3'd7);                         // down
      nb_ok[7]  = (scan_row != 3'd7) && (scan_col != 3'd7);   // down-right

      nb_idx[0] = scan_q - 6'd9;
      nb_idx[1] = scan_q - 6'd8;
      nb_idx[2] = scan_q - 6'd7;
      nb_idx[3] = scan_q - 6'd1;
      nb_idx[4] = scan_q + 6'd1;
      nb_idx[5] = scan_q + 6'd7;
      nb_idx[6] = scan_q + 6'd8;
      nb_idx[7] = scan_q + 6'd9;
   end

   always_comb begin
      nb_hit = 8'd0;
      nb_cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         nb_hit[i] = nb_ok[i] & mine_map_q[nb_idx[i]];
         nb_cnt    = nb_cnt + {3'b000, nb_hit[i]};
      end
   end

   // ------------------------------------------------------------------
   // Outputs, decoded straight from registered state
   // ------------------------------------------------------------------
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.wr_en    = wr_en;
   assign bus.wr_addr  = scan_q;
   assign bus.wr_mine  = wr_en & mine_map_q[scan_q];
   assign bus.wr_count = wr_en ? nb_cnt : 4'd0;
   assign bus.placed   = placed_q;
   assign bus.mine_map = mine_map_q;

endmodule

// File: tb/tb_mine_layout_ctrl.sv
// Self-checking bench for mine_layout_ctrl: forced random sequences, expected
// board writes and per-cycle placed counts queued up front, compared as the
// DUT streams them out.
module tb_mine_layout_ctrl;

   logic clk;
   logic reset;

   mine_layout_ctrl_if bus ();

   mine_layout_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [5:0]  rq [$];   // forced random candidates, one per PLACE cycle
   logic [10:0] wq [$];   // expected writes {addr, mine, count}
   logic [3:0]  pq [$];   // expected placed value seen in each PLACE cycle

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference neighbour count by explicit 2-D bounds test.
   function automatic logic [3:0] ref_count(input logic [63:0] m, input int r, input int c);
      int cnt;
      int rr;
      int cc;
      cnt = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
               if (m[rr * 8 + cc]) cnt++;
            end
         end
      end
      return cnt[3:0];
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},     64'(bus.busy),     64'd0);
      check({tag, "_done"},     64'(bus.done),     64'd0);
      check({tag, "_wr_en"},    64'(bus.wr_en),    64'd0);
      check({tag, "_wr_addr"},  64'(bus.wr_addr),  64'd0);
      check({tag, "_wr_mine"},  64'(bus.wr_mine),  64'd0);
      check({tag, "_wr_count"}, 64'(bus.wr_count), 64'd0);
      check({tag, "_placed"},   64'(bus.placed),   64'd0);
      check({tag, "_mine_map"}, bus.mine_map,      64'd0);
   endtask

   // Runs one layout using rq. Called at a negedge. exp_place is the PLACE
   // length the test expects; abort_at >= 0 pulls reset during that write.
   task automatic run(input logic [3:0] n, input logic [2:0] sr, input logic [2:0] sc,
                      input int exp_place, input bit poke, input int abort_at);
      logic [63:0] m;
      logic [5:0]  c;
      logic [10:0] e;
      int          p;
      int          ri;
      int          place_seen;
      bit          fin;

      wq.delete();
      pq.delete();
      m = 64'd0;
      p = 0;
      for (int k = 0; k < rq.size() && p < int'(n); k++) begin
         pq.push_back(p[3:0]);
         c = rq[k];
         if (!m[c] && c != {sr, sc}) begin
            m[c] = 1'b1;
            p++;
         end
      end
      for (int s = 0; s < 64; s++) begin
         wq.push_back({s[5:0], m[s], ref_count(m, s / 8, s % 8)});
      end

      bus.start       = 1'b1;
      bus.total_mines = n;
      bus.safe_row    = sr;
      bus.safe_col    = sc;
      ri              = 0;
      place_seen      = 0;
      fin             = 1'b0;

      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         @(negedge clk);
         if (bus.done) begin
            check("done_cycle", 64'(cyc), 64'(exp_place + 64));
            fin = 1'b1;
         end else if (bus.wr_en) begin
            e = (wq.size() > 0) ? wq.pop_front() : 11'h7ff;
            check("wr_addr",  64'(bus.wr_addr),  64'(e[10:5]));
            check("wr_mine",  64'(bus.wr_mine),  64'(e[4]));
            check("wr_count", 64'(bus.wr_count), 64'(e[3:0]));
            if (abort_at >= 0 && int'(e[10:5]) == abort_at) begin
               reset = 1'b0;
               bus.start = 1'b0;
               @(negedge clk);
               check_all_zero("abort");
               reset = 1'b1;
               return;
            end
         end else if (bus.busy) begin
            place_seen++;
            check("placed", 64'(bus.placed), 64'((pq.size() > 0) ? pq.pop_front() : 4'hf));
            if (ri < rq.size()) begin
               {bus.rand_row, bus.rand_col} = rq[ri];
               ri++;
            end
         end
         bus.start = poke && (cyc == 4 || cyc == 40);
      end
      bus.start = 1'b0;

      check("done_seen",    64'(bus.done),       64'd1);
      check("place_cycles", 64'(place_seen),     64'(exp_place));
      check("mine_map",     bus.mine_map,        m);
      check("placed_final", 64'(bus.placed),     64'(n));
      check("writes_left",  64'(wq.size()),      64'd0);
   endtask

   initial begin
      reset           = 1'b0;
      bus.start       = 1'b0;
      bus.total_mines = 4'd0;
      bus.safe_row    = 3'd0;
      bus.safe_col    = 3'd0;
      bus.rand_row    = 3'd0;
      bus.rand_col    = 3'd0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      // No mines: PLACE skipped, blank board.
      rq = {};
      run(4'd0, 3'd3, 3'd3, 0, 1'b0, -1);

      // One mine in the corner.
      rq = {6'd0};
      run(4'd1, 3'd7, 3'd7, 1, 1'b0, -1);
      check("map_corner", bus.mine_map, 64'h1);

      // Duplicate candidate rejected.
      rq = {6'd18, 6'd18, 6'd45};
      run(4'd2, 3'd0, 3'd0, 3, 1'b0, -1);
      check("map_dup", bus.mine_map, (64'd1 << 18) | (64'd1 << 45));

      // Safe cell rejected five times, then a mine at column 7 (no row wrap).
      rq = {6'd36, 6'd36, 6'd36, 6'd36, 6'd36, 6'd7};
      run(4'd1, 3'd4, 3'd4, 6, 1'b0, -1);
      check("map_safe", bus.mine_map, 64'd1 << 7);

      // Reset during COUNT at s = 20, then a fresh layout.
      rq = {6'd9, 6'd50, 6'd22};
      run(4'd3, 3'd0, 3'd0, 3, 1'b0, 20);
      rq = {6'd1, 6'd2, 6'd3, 6'd60};
      run(4'd4, 3'd6, 3'd6, 4, 1'b0, -1);

      // Fifteen mines surrounding (3,3), with a duplicate, a safe hit and
      // start pulses during PLACE and COUNT that must be ignored.
      rq = {6'd18, 6'd19, 6'd19, 6'd20, 6'd26, 6'd63, 6'd28, 6'd34, 6'd35,
            6'd36, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6};
      run(4'd15, 3'd7, 3'd7, 17, 1'b1, -1);
      check("placed_15", 64'(bus.placed), 64'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mine_layout_ctrl.md
# mine_layout_ctrl

Sequences construction of a new minesweeper layout on the 8x8 game board. On `start`, it samples the random row/column generator until it has placed `total_mines` distinct mines, rejecting duplicates and the protected first-click cell. It then scans all 64 cells, computes each cell's neighbour-mine count, and streams one write per cell into the board storage. It sits between the random generator and the game board, and is triggered by the game FSM before play begins.

## Interface
Parameters:
- none (board fixed at 8x8; cell index = row*8 + col)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin layout; sampled only in IDLE or DONE
- `total_mines`  in  4  mines to place, 0..15; latched on accepted `start`
- `safe_row`  in  3  row of protected cell, latched on accepted `start`
- `safe_col`  in  3  column of protected cell, latched on accepted `start`
- `rand_row`  in  3  random generator row, new value every cycle
- `rand_col`  in  3  random generator column, new value every cycle
- `busy`  out  1  high in PLACE and COUNT
- `done`  out  1  high in DONE
- `wr_en`  out  1  board write strobe, high every COUNT cycle
- `wr_addr`  out  6  cell index being written
- `wr_mine`  out  1  cell holds a mine
- `wr_count`  out  4  mined neighbours of cell, 0..8
- `placed`  out  4  mines placed so far
- `mine_map`  out  64  registered mine bitmap, bit i = cell i

## Operation
- FSM states: IDLE, PLACE, COUNT, DONE.
- IDLE:
  - On `start`, latch `total_mines`, `safe_row` and `safe_col`.
  - Clear `mine_map` and `placed`.
  - Go to PLACE if `total_mines` is not 0; go to COUNT if it is 0.
- PLACE, each cycle:
  - Candidate index c = `{rand_row, rand_col}`.
  - Accept c if `mine_map[c]` is 0 and c is not the safe cell.
  - On accept: set `mine_map[c]` and increment `placed`.
  - On reject: no state change.
  - When an accept makes `placed` equal the latched total, go to COUNT on the next edge.
- COUNT:
  - 6-bit scan counter s runs from 0 to 63, one cell per cycle.
  - `wr_en` = 1, `wr_addr` = s, `wr_mine` = `mine_map[s]`.
  - `wr_count` = popcount of the up-to-8 in-bounds neighbours (row±1, col±1).
  - Out-of-range neighbours are excluded. No wrap: col 7 is not adjacent to col 0 of the next row.
  - `wr_count` is computed for mined cells too.
  - After the s = 63 write, go to DONE.
- DONE:
  - `done` held high; `mine_map` and `placed` held.
  - `start` re-enters the IDLE action (relatch, clear map) and begins a new layout.
- `start` is ignored in PLACE and COUNT.
- Outputs are decoded from the registered state, s and `mine_map`. No extra pipeline stage.

## Timing
- Reset values (asynchronous, `reset` = 0):
  - state IDLE, `busy` 0, `done` 0, `wr_en` 0.
  - `wr_addr` 0, `wr_mine` 0, `wr_count` 0, `placed` 0, `mine_map` 0, s 0.
- Cycle 0: `start` sampled at edge E0. From E0, state is PLACE (or COUNT if N = 0).
- PLACE lasts N + R cycles, where R is the number of rejected candidates.
  - A candidate is accepted at the edge ending its cycle.
  - `placed` and `mine_map` update at that edge.
- COUNT lasts exactly 64 cycles, `wr_en` high in all of them. The board captures each write at the edge ending that cycle.
- `done` rises at the edge after the s = 63 write cycle.
- Best-case start-to-done latency is N + 64 cycles.
- Reset asserted mid-PLACE or mid-COUNT:
  - Immediate return to IDLE with all outputs at reset values.
  - Partial board writes are abandoned, not completed.
- Termination: at most 15 mines against 63 legal cells, so PLACE always terminates for a generator covering all cells. The block has no timeout.

## Test plan
- N = 0, safe (3,3): `start` → PLACE skipped, 64 writes with `wr_mine` = 0 and `wr_count` = 0, `done` at cycle 64.
- N = 1, rand forced (0,0), safe (7,7):
  - `mine_map` = 0x1.
  - Writes: addr 1, 8, 9 have `wr_count` = 1; addr 0 has `wr_mine` = 1, `wr_count` = 0; all others 0.
  - `done` at cycle 65.
- N = 2, rand sequence (2,2), (2,2), (5,5):
  - Duplicate rejected, `placed` goes 1, 1, 2.
  - PLACE lasts 3 cycles.
  - Addr 27 has `wr_count` = 1; addr 36 has `wr_count` = 1.
- Safe-cell rejection: safe (4,4), rand (4,4) for 5 cycles then (0,7):
  - `placed` stays 0 for 5 cycles, then mine at addr 7.
  - Addr 15 has `wr_count` = 1; no wrap count at addr 8.
- Reset mid-COUNT at s = 20 → next cycle all outputs 0, state IDLE. A fresh `start` completes a normal layout.
- N = 15, neighbours of (3,3) all mined first: addr 27 `wr_count` = 8, `placed` = 15, `start` during busy ignored.
